// File: rtl/data_mem_responder.sv
// Data-side memory responder for the load/store path. It accepts a level
// ld/st request, holds wait_data while a fixed-latency access to the internal
// word RAM runs, and signals data_segv for illegal requests. Load results are
// registered in rdata and announced by a one-cycle rdata_valid strobe.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic        st,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        wait_data,
  output logic        data_segv
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The counter only has to hold LATENCY-1.
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    is_ld_q, is_ld_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [31:0]             mem [DEPTH];

  logic                    req_legal;
  logic                    commit;

  // Exactly one of ld/st, word aligned, and no address bits above the RAM.
  assign req_legal = (ld ^ st) && (addr[1:0] == 2'b00) &&
                     ((addr >> (ADDR_WIDTH + 2)) == 32'd0);

  // The access takes effect on the last ACCESS cycle.
  assign commit = (state_q == S_ACCESS) && (cnt_q == '0);

  // Next-state logic: request capture in IDLE, latency countdown in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_ld_d = is_ld_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ld || st) begin
          if (req_legal) begin
            state_d = S_ACCESS;
            is_ld_d = ld;
            idx_d   = addr[ADDR_WIDTH+1:2];
            wdata_d = wdata;
            cnt_d   = CW'(LATENCY - 1);
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (is_ld_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (!(ld || st)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and load-result registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_ld_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_ld_q <= is_ld_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write port; contents survive reset, but a reset on the commit edge
  // suppresses the write so an aborted store leaves memory untouched.
  always_ff @(posedge clk) begin
    if (!reset && commit && !is_ld_q) mem[idx_q] <= wdata_q;
  end

  assign wait_data   = ((state_q == S_IDLE) && (ld || st)) || (state_q == S_ACCESS);
  assign rdata_valid = (state_q == S_DONE) && is_ld_q;
  assign data_segv   = (state_q == S_FAULT);
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed handshake scenarios plus a random
// mix of legal and faulting requests against a word-array reference model.
module tb_data_mem_responder;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ld, st;
  logic [31:0] addr, wdata, rdata;
  logic        rdata_valid, wait_data, data_segv;

  logic        ld1, st1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rv1, wd1, sg1;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u0 (
    .clk(clk), .reset(reset), .ld(ld), .st(st), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .wait_data(wait_data),
    .data_segv(data_segv));

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .ld(ld1), .st(st1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .rdata_valid(rv1), .wait_data(wd1), .data_segv(sg1));

  int total  = 0;
  int passed = 0;

  // Reference model: RAM words written so far, and the expected rdata.
  logic [31:0] ref_mem [int];
  logic [31:0] rd_exp;
  bit          rd_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit legal(input bit l, input bit s, input logic [31:0] a);
    return (l != s) && (a % 4 == 0) && (a < 4 * (1 << AW));
  endfunction

  // Legal access: wait_data high for LAT+1 cycles, then the DONE cycle.
  // Returns during DONE with the request still asserted.
  task automatic run_req(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a / 4);
    @(posedge clk); #1 ld = l; st = s; addr = a; wdata = d;
    @(negedge clk);
    chk("req_wait_c0", wait_data, 1);
    chk("req_valid_c0", rdata_valid, 0);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1 addr = $urandom; wdata = $urandom;
      @(negedge clk);
      chk("req_wait_acc", wait_data, 1);
      chk("req_valid_acc", rdata_valid, 0);
      chk("req_segv_acc", data_segv, 0);
    end
    if (s) ref_mem[idx] = d;
    else if (ref_mem.exists(idx)) begin rd_exp = ref_mem[idx]; rd_known = 1; end
    else rd_known = 0;
    @(posedge clk);
    @(negedge clk);
    chk("done_wait", wait_data, 0);
    chk("done_valid", rdata_valid, {31'd0, l});
    if (rd_known) chk("done_rdata", rdata, rd_exp);
  endtask

  // Faulting access held for 'hold' FAULT cycles, then withdrawn.
  task automatic run_fault(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d,
                           input int hold);
    @(posedge clk); #1 ld = l; st = s; addr = a; wdata = d;
    @(negedge clk);
    chk("flt_wait_c0", wait_data, 1);
    chk("flt_segv_c0", data_segv, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1 addr = $urandom;
      @(negedge clk);
      chk("flt_segv_held", data_segv, 1);
      chk("flt_wait_held", wait_data, 0);
    end
    @(posedge clk); #1 ld = 0; st = 0;
    @(negedge clk);
    chk("flt_segv_drop", data_segv, 1);
    @(posedge clk);
    @(negedge clk);
    chk("flt_segv_clr", data_segv, 0);
    chk("flt_wait_clr", wait_data, 0);
  endtask

  task automatic req(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d);
    if (legal(l, s, a)) run_req(l, s, a, d);
    else run_fault(l, s, a, d, $urandom_range(1, 3));
  endtask

  // Withdraw the request and confirm the quiet IDLE outputs.
  task automatic idle();
    @(posedge clk); #1 ld = 0; st = 0;
    @(negedge clk);
    chk("idle_wait", wait_data, 0);
    chk("idle_valid", rdata_valid, 0);
    chk("idle_segv", data_segv, 0);
    if (rd_known) chk("idle_rdata", rdata, rd_exp);
  endtask

  initial begin
    reset = 1; ld = 0; st = 0; addr = 0; wdata = 0;
    ld1 = 0; st1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_wait", wait_data, 0);
    chk("rst_segv", data_segv, 0);
    @(posedge clk); #1 reset = 0;
    rd_exp = 0; rd_known = 1;

    // Store then load the same word.
    req(0, 1, 32'h010, 32'hDEADBEEF); idle();
    req(1, 0, 32'h010, 32'h0);        idle();

    // Highest word is legal, the next one faults and leaves RAM alone.
    req(0, 1, 32'h3FC, 32'h12345678); idle();
    req(1, 0, 32'h3FC, 32'h0);        idle();
    req(1, 0, 32'h400, 32'h0);
    req(1, 0, 32'h3FC, 32'h0);        idle();

    // Misaligned store and ld&st both fault without writing.
    req(0, 1, 32'h000, 32'h11111111); idle();
    req(0, 1, 32'h002, 32'hFFFFFFFF);
    req(1, 1, 32'h000, 32'hEEEEEEEE);
    req(1, 0, 32'h000, 32'h0);        idle();

    // Back-to-back: store held through DONE straight into a load.
    req(0, 1, 32'h020, 32'h00000001);
    req(1, 0, 32'h020, 32'h0);        idle();

    // Reset on the commit edge of a store aborts it.
    req(0, 1, 32'h040, 32'h0BADF00D); idle();
    @(posedge clk); #1 st = 1; addr = 32'h040; wdata = 32'hAAAA5555;
    @(negedge clk); chk("rst_acc_c0", wait_data, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(negedge clk); chk("rst_acc_wait", wait_data, 1);
    @(posedge clk); #1 reset = 0; st = 0;
    @(negedge clk);
    chk("rst_acc_wait0", wait_data, 0);
    chk("rst_acc_valid", rdata_valid, 0);
    chk("rst_acc_segv", data_segv, 0);
    chk("rst_acc_rdata", rdata, 0);
    rd_exp = 0; rd_known = 1;
    req(1, 0, 32'h040, 32'h0);        idle();

    // Reset while faulting clears data_segv even with ld still high.
    @(posedge clk); #1 ld = 1; addr = 32'h400;
    @(negedge clk); chk("rst_flt_c0", wait_data, 1);
    @(posedge clk);
    @(negedge clk); chk("rst_flt_segv", data_segv, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_flt_segv0", data_segv, 0);
    chk("rst_flt_wait", wait_data, 1);
    @(posedge clk); #1 reset = 0; ld = 0;
    @(negedge clk);
    chk("rst_flt_idle", wait_data, 0);
    rd_exp = 0; rd_known = 1;

    // Seed a small word pool, then a random mix of legal and illegal traffic.
    for (int w = 0; w < 16; w++) begin
      req(0, 1, 32'(w * 4), $urandom); idle();
    end
    for (int n = 0; n < 60; n++) begin
      int kind;
      int w;
      bit l;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 16);
      l    = 1'($urandom_range(0, 1));
      a    = (w == 16) ? 32'h3FC : 32'(w * 4);
      case (kind)
        0:       req(l, !l, a | 32'($urandom_range(1, 3)), $urandom);
        1:       req(l, !l, $urandom | 32'h400, $urandom);
        2:       req(1, 1, a, $urandom);
        default: req(l, !l, a, $urandom);
      endcase
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // LATENCY=1 instance: two wait cycles, addr change in ACCESS ignored.
    @(posedge clk); #1 st1 = 1; addr1 = 32'h008; wdata1 = 32'hC0FFEE01;
    @(negedge clk); chk("l1_st_c0", wd1, 1);
    @(posedge clk); #1 addr1 = 32'h010; wdata1 = $urandom;
    @(negedge clk); chk("l1_st_acc", wd1, 1);
    @(posedge clk);
    @(negedge clk); chk("l1_st_done", wd1, 0); chk("l1_st_valid", rv1, 0);
    @(posedge clk); #1 st1 = 0;
    @(posedge clk); #1 ld1 = 1; addr1 = 32'h008;
    @(negedge clk); chk("l1_ld_c0", wd1, 1);
    @(posedge clk); #1 addr1 = 32'h010;
    @(negedge clk); chk("l1_ld_acc", wd1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_ld_done", wd1, 0);
    chk("l1_ld_valid", rv1, 1);
    chk("l1_ld_rdata", rdata1, 32'hC0FFEE01);
    chk("l1_ld_segv", sg1, 0);
    @(posedge clk); #1 ld1 = 0;
    @(negedge clk); chk("l1_valid_once", rv1, 0); chk("l1_idle_wait", wd1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
